// File: rtl/systolic_pkg.sv
// Shared types and helpers for the parametrised systolic matrix-multiply engine.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Cycles needed after the last beat for PE(N-1,N-1) to see its final operands.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

    // Low bit index of lane `lane` in a packed bus of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: multiply-accumulate plus east/south forwarding.
module systolic_pe #(
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DW-1:0]    in_west,
    input  logic [DW-1:0]    in_north,
    output logic [DW-1:0]    out_east,
    output logic [DW-1:0]    out_south,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] prod_ext;

    if (SIGNED != 0) begin : g_signed
        logic signed [2*DW-1:0] prod;
        assign prod     = $signed({{DW{in_west[DW-1]}}, in_west}) *
                          $signed({{DW{in_north[DW-1]}}, in_north});
        assign prod_ext = ACC_W'(prod);
    end else begin : g_unsigned
        logic [2*DW-1:0] prod;
        assign prod     = {{DW{1'b0}}, in_west} * {{DW{1'b0}}, in_north};
        assign prod_ext = ACC_W'(prod);
    end

    // Accumulate the product and pass operands on to the neighbouring PEs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_east  <= '0;
            out_south <= '0;
        end else if (clr) begin
            acc       <= '0;
            out_east  <= '0;
            out_south <= '0;
        end else begin
            acc       <= acc + prod_ext;
            out_east  <= in_west;
            out_south <= in_north;
        end
    end

endmodule

// File: rtl/systolic_array_param.sv
// N x N output-stationary systolic array with input skew, job control and row readout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; start clears accumulators, latches k_len
// S_FEED  | in_ready=1, accepting k_len beats (bubbles inject zeros)
// S_DRAIN | zeros flow in until the far corner PE has its last product
// S_OUT   | presenting accumulator rows 0..N-1 on a ready/valid handshake
module systolic_array_param
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int KW     = 8,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DW-1:0]        in_west,
    input  logic [N*DW-1:0]        in_north,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_row_idx,
    output logic [N*ACC_W-1:0]     out_row,
    output logic                   done
);

    localparam int IW   = $clog2(N);
    localparam int DC_W = $clog2(2 * N);
    localparam logic [IW-1:0]   LAST_ROW   = IW'(N - 1);
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(drain_cycles(N) - 1);

    state_t           state;
    logic [KW-1:0]    beats_left;
    logic [DC_W-1:0]  drain_cnt;
    logic             accept;
    logic             clr;

    logic [DW-1:0]    feed_w  [N];
    logic [DW-1:0]    feed_n  [N];
    logic [DW-1:0]    edge_w  [N];
    logic [DW-1:0]    edge_n  [N];
    logic [DW-1:0]    east_q  [N][N];
    logic [DW-1:0]    south_q [N][N];
    logic [ACC_W-1:0] acc_q   [N][N];

    assign accept = in_ready & in_valid;
    assign clr    = (state == S_IDLE) & start;

    // Gate host lanes: only accepted beats carry data, everything else is a zero bubble.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            feed_w[i] = accept ? in_west[lane_lo(i, DW) +: DW]  : '0;
            feed_n[i] = accept ? in_north[lane_lo(i, DW) +: DW] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_d0
            assign edge_w[i] = feed_w[i];
            assign edge_n[i] = feed_n[i];
        end else begin : g_dn
            logic [DW-1:0] w_sr [i];
            logic [DW-1:0] n_sr [i];

            // Lane i is delayed i cycles so rows/columns meet on the array diagonal.
            always_ff @(posedge clk or posedge rst) begin
                if (rst || clr) begin
                    for (int d = 0; d < i; d++) begin
                        w_sr[d] <= '0;
                        n_sr[d] <= '0;
                    end
                end else begin
                    w_sr[0] <= feed_w[i];
                    n_sr[0] <= feed_n[i];
                    for (int d = 1; d < i; d++) begin
                        w_sr[d] <= w_sr[d-1];
                        n_sr[d] <= n_sr[d-1];
                    end
                end
            end

            assign edge_w[i] = w_sr[i-1];
            assign edge_n[i] = n_sr[i-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            systolic_pe #(
                .DW     (DW),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk       (clk),
                .rst       (rst),
                .clr       (clr),
                .in_west   ((c == 0) ? edge_w[r] : east_q[r][(c == 0) ? 0 : c-1]),
                .in_north  ((r == 0) ? edge_n[c] : south_q[(r == 0) ? 0 : r-1][c]),
                .out_east  (east_q[r][c]),
                .out_south (south_q[r][c]),
                .acc       (acc_q[r][c])
            );
        end
    end

    // Present the selected accumulator row; accumulators are frozen during OUT.
    always_comb begin
        out_row = '0;
        for (int j = 0; j < N; j++) begin
            out_row[j*ACC_W +: ACC_W] = acc_q[out_row_idx][j];
        end
    end

    // Job sequencing with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            beats_left  <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            out_row_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (k_len == '0) begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                        end else begin
                            state      <= S_FEED;
                            in_ready   <= 1'b1;
                            beats_left <= k_len;
                        end
                    end
                end
                S_FEED: begin
                    if (accept) begin
                        beats_left <= beats_left - KW'(1);
                        if (beats_left == KW'(1)) begin
                            state     <= S_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DC_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_row_idx == LAST_ROW) begin
                            state       <= S_IDLE;
                            out_row_idx <= '0;
                            out_valid   <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            out_row_idx <= out_row_idx + IW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_array_param.sv
// Directed bench for systolic_array_param: an unsigned and a signed instance share stimulus.
module tb_systolic_array_param;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int KW    = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 in_valid;
    logic                 out_ready;
    logic [N*DW-1:0]      in_west;
    logic [N*DW-1:0]      in_north;

    logic                 u_busy, u_in_ready, u_out_valid, u_done;
    logic [1:0]           u_idx;
    logic [N*ACC_W-1:0]   u_row;
    logic                 s_busy, s_in_ready, s_out_valid, s_done;
    logic [1:0]           s_idx;
    logic [N*ACC_W-1:0]   s_row;

    always #5 clk = ~clk;

    systolic_array_param #(.N(N), .DW(DW), .ACC_W(ACC_W), .KW(KW), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(u_busy),
        .in_valid(in_valid), .in_ready(u_in_ready), .in_west(in_west), .in_north(in_north),
        .out_valid(u_out_valid), .out_ready(out_ready), .out_row_idx(u_idx),
        .out_row(u_row), .done(u_done)
    );

    systolic_array_param #(.N(N), .DW(DW), .ACC_W(ACC_W), .KW(KW), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(s_busy),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_west(in_west), .in_north(in_north),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_row_idx(s_idx),
        .out_row(s_row), .done(s_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]         ma [4][4];
    logic [7:0]         mb [4][4];
    logic [N*ACC_W-1:0] got_u [4];
    logic [N*ACC_W-1:0] got_s [4];
    logic [1:0]         got_idx [4];
    logic               got_valid [4];
    logic [1:0]         stall_idx [5];
    logic [N*ACC_W-1:0] stall_row [5];
    logic [N*ACC_W-1:0] er;
    logic [N*ACC_W-1:0] es;
    int                 lat;
    bit                 timed_out;
    logic               got_done, got_busy, got_valid_after, got_done2, done_early, ready_low_seen;
    logic [1:0]         got_idx_after;

    task automatic start_job(input int k);
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Beat kk carries A column kk on the west lanes and B row kk on the north lanes.
    task automatic feed(input int k, input bit gaps);
        ready_low_seen = 1'b0;
        for (int kk = 0; kk < k; kk++) begin
            if (u_in_ready !== 1'b1) ready_low_seen = 1'b1;
            for (int i = 0; i < N; i++) begin
                in_west[i*DW +: DW]  = ma[i][kk];
                in_north[i*DW +: DW] = mb[kk][i];
            end
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (gaps && kk < k - 1) begin
                if (u_in_ready !== 1'b1) ready_low_seen = 1'b1;
                in_valid = 1'b0;
                in_west  = 32'hAAAA_AAAA;
                in_north = 32'h5555_5555;
                @(posedge clk);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_west  = '0;
        in_north = '0;
    endtask

    // Waits (bounded) for OUT, optionally stalls or pokes start, then records all rows.
    task automatic collect(input int stall, input bit poke);
        timed_out  = 1'b0;
        lat        = 0;
        done_early = 1'b0;
        while (u_out_valid !== 1'b1) begin
            if (lat >= 100) begin
                timed_out = 1'b1;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (poke) begin
            start = 1'b1;
            k_len = 8'd2;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        for (int s = 0; s < stall; s++) begin
            stall_idx[s] = u_idx;
            stall_row[s] = u_row;
            if (u_done) done_early = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        for (int r = 0; r < 4; r++) begin
            got_idx[r]   = u_idx;
            got_valid[r] = u_out_valid;
            got_u[r]     = u_row;
            got_s[r]     = s_row;
            if (u_done) done_early = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
        got_done        = u_done;
        got_busy        = u_busy;
        got_valid_after = u_out_valid;
        got_idx_after   = u_idx;
        @(posedge clk);
        @(negedge clk);
        got_done2 = u_done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_west = '0; in_north = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({u_busy, u_in_ready, u_out_valid, u_done, u_idx} !== 6'b0 || u_row !== '0)
            $display("FAIL reset_u: busy/rdy/val/done/idx=%b row=%h want all 0",
                     {u_busy, u_in_ready, u_out_valid, u_done, u_idx}, u_row);
        else n_pass++;
        n_checks++;
        if ({s_busy, s_in_ready, s_out_valid, s_done, s_idx} !== 6'b0 || s_row !== '0)
            $display("FAIL reset_s: busy/rdy/val/done/idx=%b row=%h want all 0",
                     {s_busy, s_in_ready, s_out_valid, s_done, s_idx}, s_row);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 8'd1 : 8'd0;
                mb[i][j] = 8'(16 * i + j + 1);
            end
        start_job(4);
        n_checks++;
        if (u_busy !== 1'b1 || u_in_ready !== 1'b1)
            $display("FAIL id_busy_after_start: busy=%b in_ready=%b want 1 1", u_busy, u_in_ready);
        else n_pass++;
        feed(4, 1'b0);
        collect(0, 1'b0);
        n_checks++;
        if (timed_out) $display("FAIL id_timeout: out_valid never rose within 100 cycles");
        else n_pass++;
        n_checks++;
        if (lat !== 2 * N - 1)
            $display("FAIL id_latency: %0d edges after last beat want %0d", lat, 2 * N - 1);
        else n_pass++;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) er[j*32 +: 32] = 32'(16 * r + j + 1);
            n_checks++;
            if (got_idx[r] !== 2'(r) || got_valid[r] !== 1'b1 || got_u[r] !== er)
                $display("FAIL id_row%0d: idx=%0d valid=%b row=%h want idx=%0d valid=1 row=%h",
                         r, got_idx[r], got_valid[r], got_u[r], r, er);
            else n_pass++;
        end
        n_checks++;
        if (got_done !== 1'b1 || got_busy !== 1'b0 || got_valid_after !== 1'b0 || got_idx_after !== 2'd0)
            $display("FAIL id_finish: done=%b busy=%b valid=%b idx=%0d want 1 0 0 0",
                     got_done, got_busy, got_valid_after, got_idx_after);
        else n_pass++;
        n_checks++;
        if (got_done2 !== 1'b0 || done_early !== 1'b0)
            $display("FAIL id_done_once: done_next=%b done_early=%b want 0 0", got_done2, done_early);
        else n_pass++;
    endtask

    task automatic test_max_unsigned();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 8'hFF;
                mb[i][j] = 8'hFF;
            end
        start_job(4);
        feed(4, 1'b0);
        collect(0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            er[j*32 +: 32] = 32'h0003_F804;
            es[j*32 +: 32] = 32'd4;
        end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_u[r] !== er)
                $display("FAIL max_u_row%0d: got %h want %h", r, got_u[r], er);
            else n_pass++;
            n_checks++;
            if (got_s[r] !== es)
                $display("FAIL max_s_row%0d: got %h want %h", r, got_s[r], es);
            else n_pass++;
        end
    endtask

    task automatic test_signed();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 8'h80;
                mb[i][j] = 8'h80;
            end
        start_job(4);
        feed(4, 1'b0);
        collect(0, 1'b0);
        for (int j = 0; j < 4; j++) er[j*32 +: 32] = 32'd65536;
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_s[r] !== er || got_u[r] !== er)
                $display("FAIL neg128_row%0d: signed=%h unsigned=%h want %h", r, got_s[r], got_u[r], er);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 8'hFF;
                mb[i][j] = 8'h01;
            end
        start_job(4);
        feed(4, 1'b0);
        collect(0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            es[j*32 +: 32] = 32'hFFFF_FFFC;
            er[j*32 +: 32] = 32'd1020;
        end
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_s[r] !== es)
                $display("FAIL minus1_s_row%0d: got %h want %h", r, got_s[r], es);
            else n_pass++;
            n_checks++;
            if (got_u[r] !== er)
                $display("FAIL minus1_u_row%0d: got %h want %h", r, got_u[r], er);
            else n_pass++;
        end
    endtask

    // A[i][k]=i+1, B[k][j]=k+j, K=3  ->  C[i][j] = 3*(i+1)*(j+1)
    task automatic test_bubbles();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = 8'(i + 1);
                mb[k][i] = 8'(k + i);
            end
        for (int pass = 0; pass < 2; pass++) begin
            start_job(3);
            feed(3, pass == 1);
            collect(0, 1'b0);
            n_checks++;
            if (timed_out || lat !== 2 * N - 1)
                $display("FAIL bub%0d_latency: timeout=%b edges=%0d want 0 %0d", pass, timed_out, lat, 2 * N - 1);
            else n_pass++;
            for (int r = 0; r < 4; r++) begin
                for (int j = 0; j < 4; j++) er[j*32 +: 32] = 32'(3 * (r + 1) * (j + 1));
                n_checks++;
                if (got_u[r] !== er)
                    $display("FAIL bub%0d_row%0d: got %h want %h", pass, r, got_u[r], er);
                else n_pass++;
            end
        end
        n_checks++;
        if (ready_low_seen !== 1'b0)
            $display("FAIL bub_in_ready: in_ready dropped during gapped FEED (seen=%b want 0)", ready_low_seen);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 8'd1 : 8'd0;
                mb[i][j] = 8'(16 * i + j + 1);
            end
        start_job(4);
        feed(4, 1'b0);
        collect(5, 1'b0);
        for (int j = 0; j < 4; j++) er[j*32 +: 32] = 32'(j + 1);
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (stall_idx[s] !== 2'd0 || stall_row[s] !== er)
                $display("FAIL stall%0d: idx=%0d row=%h want idx=0 row=%h", s, stall_idx[s], stall_row[s], er);
            else n_pass++;
        end
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) er[j*32 +: 32] = 32'(16 * r + j + 1);
            n_checks++;
            if (got_idx[r] !== 2'(r) || got_u[r] !== er)
                $display("FAIL stall_row%0d: idx=%0d row=%h want idx=%0d row=%h", r, got_idx[r], got_u[r], r, er);
            else n_pass++;
        end
        n_checks++;
        if (got_done !== 1'b1 || done_early !== 1'b0)
            $display("FAIL stall_done: done=%b early=%b want 1 0", got_done, done_early);
        else n_pass++;
    endtask

    task automatic test_reset_midfeed();
        start_job(4);
        in_west  = 32'h0303_0303;
        in_north = 32'h0505_0505;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({u_busy, u_in_ready, u_out_valid, u_done, u_idx} !== 6'b0 || u_row !== '0)
            $display("FAIL midfeed_reset: busy/rdy/val/done/idx=%b row=%h want all 0",
                     {u_busy, u_in_ready, u_out_valid, u_done, u_idx}, u_row);
        else n_pass++;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_west  = '0;
        in_north = '0;
        start_job(0);
        collect(0, 1'b1);
        n_checks++;
        if (timed_out || lat !== 0)
            $display("FAIL k0_direct_out: timeout=%b edges=%0d want 0 0", timed_out, lat);
        else n_pass++;
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (got_idx[r] !== 2'(r) || got_u[r] !== '0 || got_s[r] !== '0)
                $display("FAIL k0_row%0d: idx=%0d u=%h s=%h want idx=%0d rows 0", r, got_idx[r], got_u[r], got_s[r], r);
            else n_pass++;
        end
        n_checks++;
        if (got_done !== 1'b1 || got_busy !== 1'b0)
            $display("FAIL k0_done: done=%b busy=%b want 1 0", got_done, got_busy);
        else n_pass++;
        n_checks++;
        if (u_busy !== 1'b0 || u_in_ready !== 1'b0 || u_out_valid !== 1'b0)
            $display("FAIL start_in_out_ignored: busy=%b in_ready=%b out_valid=%b want 0 0 0",
                     u_busy, u_in_ready, u_out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_max_unsigned();
        test_signed();
        test_bubbles();
        test_stall();
        test_reset_midfeed();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
